// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard and forwarding controller for a 5-stage RV32 pipeline. Keeps its own
// shadow copy of the destination-register state of the instructions in EX and
// MEM. It produces the registered forwarding selects for the EX operand muxes,
// the load-use stall and bubble, the branch-flush bubble, and a pipeline freeze
// while the multi-cycle MAC unit is busy. A watchdog on the MAC unit limits how
// long the freeze can last.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1/id_rs2            source registers in ID
//   id_use_rs1/id_use_rs2    ID instruction reads rs1/rs2
//   id_rd, id_regwrite       destination register and write enable in ID
//   id_memread               ID instruction is a load
//   id_mc                    ID instruction is a multi-cycle MAC op
//   ex_flush                 taken branch/jump resolved in EX
//   mc_done                  MAC result valid (one-cycle pulse)
//   M1Sel/M2Sel              EX operand selects: 10 ALU_MEM, 01 dataW_WB, 00 RF
//   pc_hold, ifid_hold       hold PC / IF-ID register
//   idex_bubble              load a NOP into ID/EX
//   freeze                   hold every pipeline register
//   mc_start                 one-cycle start pulse to the MAC unit
//   mc_timeout               one-cycle pulse when the MAC watchdog expires
//
// MC FSM
//   state   | meaning
//   IDLE    | no MAC operation outstanding, pipeline flows
//   MC_BUSY | MAC op sitting in EX, pipeline frozen until mc_done or watchdog
//
// The WB stage is not shadowed: a WB match never needs forwarding because the
// register file writes before it reads, so its contents would never be used.
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
   parameter int RA_W   = 5,
   parameter int MC_MAX = 64,
   parameter int CNT_W  = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            id_mc,
   input  logic            ex_flush,
   input  logic            mc_done,
   output logic [1:0]      M1Sel,
   output logic [1:0]      M2Sel,
   output logic            pc_hold,
   output logic            ifid_hold,
   output logic            idex_bubble,
   output logic            freeze,
   output logic            mc_start,
   output logic            mc_timeout
);

   typedef enum logic {
      IDLE    = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_MAX - 1);
   localparam logic [RA_W-1:0]  X0       = '0;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  mc_cnt;

   logic [RA_W-1:0]   ex_rd, mem_rd;
   logic              ex_rw, ex_mr, mem_rw;

   logic              ex_wr, mem_wr;
   logic              lu, mc_expire, frz, adv, mc_go;
   logic [1:0]        sel1_nxt, sel2_nxt;

   // Nearest producer wins: EX result comes off the ALU_MEM path, MEM result
   // off the dataW_WB path. x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [RA_W-1:0] rs,
      input logic            use_rs,
      input logic [RA_W-1:0] e_rd,
      input logic            e_wr,
      input logic [RA_W-1:0] m_rd,
      input logic            m_wr
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_rs && (rs != X0)) begin
         if (e_wr && (rs == e_rd))
            sel = 2'b10;
         else if (m_wr && (rs == m_rd))
            sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      ex_wr       = 1'b0;
      mem_wr      = 1'b0;
      lu          = 1'b0;
      mc_expire   = 1'b0;
      frz         = 1'b0;
      adv         = 1'b0;
      mc_go       = 1'b0;
      sel1_nxt    = 2'b00;
      sel2_nxt    = 2'b00;
      state_nxt   = state;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      idex_bubble = 1'b0;
      freeze      = 1'b0;

      ex_wr  = ex_rw  && (ex_rd  != X0);
      mem_wr = mem_rw && (mem_rd != X0);

      lu = id_valid && ex_mr && ex_wr &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

      // Watchdog expiry releases the pipeline in the same cycle, exactly as
      // a mc_done would.
      mc_expire = (state == MC_BUSY) && !mc_done && (mc_cnt == CNT_LAST);
      frz       = (state == MC_BUSY) && !mc_done && !mc_expire;
      adv       = !frz && !ex_flush && !lu;
      mc_go     = (state == IDLE) && adv && id_valid && id_mc;

      // Selects belong to the instruction about to enter EX; a bubble gets 00.
      if (adv) begin
         sel1_nxt = fwd_sel(id_rs1, id_valid && id_use_rs1, ex_rd, ex_wr, mem_rd, mem_wr);
         sel2_nxt = fwd_sel(id_rs2, id_valid && id_use_rs2, ex_rd, ex_wr, mem_rd, mem_wr);
      end

      if (frz) begin
         pc_hold   = 1'b1;
         ifid_hold = 1'b1;
         freeze    = 1'b1;
      end else if (ex_flush) begin
         idex_bubble = 1'b1;
      end else if (lu) begin
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
      end

      case (state)
         IDLE:    if (mc_go) state_nxt = MC_BUSY;
         MC_BUSY: if (mc_done || mc_expire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mc_cnt     <= '0;
         mc_start   <= 1'b0;
         mc_timeout <= 1'b0;
         ex_rd      <= '0;
         ex_rw      <= 1'b0;
         ex_mr      <= 1'b0;
         mem_rd     <= '0;
         mem_rw     <= 1'b0;
         M1Sel      <= 2'b00;
         M2Sel      <= 2'b00;
      end else begin
         state      <= state_nxt;
         mc_start   <= mc_go;
         mc_timeout <= mc_expire;

         // Only frozen cycles count, so the counter can never pass CNT_LAST.
         if (mc_go)
            mc_cnt <= '0;
         else if (frz)
            mc_cnt <= mc_cnt + CNT_W'(1);

         if (!frz) begin
            mem_rd <= ex_rd;
            mem_rw <= ex_rw;
            M1Sel  <= sel1_nxt;
            M2Sel  <= sel2_nxt;
            if (adv && id_valid) begin
               ex_rd <= id_rd;
               ex_rw <= id_regwrite;
               ex_mr <= id_memread;
            end else begin
               ex_rd <= '0;
               ex_rw <= 1'b0;
               ex_mr <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

   localparam int RA_W   = 5;
   localparam int MC_MAX = 64;
   localparam int CNT_W  = 7;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid;
   logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
   logic            id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_mc;
   logic            ex_flush, mc_done;
   logic [1:0]      M1Sel, M2Sel;
   logic            pc_hold, ifid_hold, idex_bubble, freeze, mc_start, mc_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_fwd_ctrl #(.RA_W(RA_W), .MC_MAX(MC_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_mc(id_mc), .ex_flush(ex_flush), .mc_done(mc_done),
      .M1Sel(M1Sel), .M2Sel(M2Sel), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
      .idex_bubble(idex_bubble), .freeze(freeze),
      .mc_start(mc_start), .mc_timeout(mc_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // In-flight instructions still able to supply a result, youngest first:
   // slot 0 is in EX, slot 1 is in MEM.
   typedef struct packed {
      logic [RA_W-1:0] rd;
      logic            wr;
      logic            ld;
   } slot_t;

   slot_t      pipe [2];
   logic       m_busy;
   int         m_busy_cycles;
   logic       m_lu, m_expired;
   logic [1:0] e_sel1, e_sel2;
   logic       e_start, e_to;
   logic       e_pc, e_ifid, e_bub, e_frz;

   function automatic logic produces(slot_t s);
      return s.wr && (s.rd != 0);
   endfunction

   // Distance to the closest in-flight producer decides the mux path.
   function automatic logic [1:0] ref_sel(logic [RA_W-1:0] rs, logic use_it);
      if (!id_valid || !use_it || rs == 0) return 2'b00;
      for (int d = 0; d < 2; d++)
         if (produces(pipe[d]) && pipe[d].rd == rs)
            return (d == 0) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   task automatic model_comb();
      logic stalled;
      m_lu = id_valid && pipe[0].ld && produces(pipe[0]) &&
             ((id_use_rs1 && id_rs1 == pipe[0].rd) || (id_use_rs2 && id_rs2 == pipe[0].rd));
      m_expired = m_busy && !mc_done && (m_busy_cycles + 1 == MC_MAX);
      stalled   = m_busy && !mc_done && !m_expired;
      e_frz  = stalled;
      e_pc   = stalled || (!ex_flush && m_lu);
      e_ifid = e_pc;
      e_bub  = !stalled && (ex_flush || m_lu);
   endtask

   task automatic model_update();
      logic       adv, start;
      logic [1:0] n1, n2;
      if (rst) begin
         pipe[0] = '0; pipe[1] = '0;
         m_busy = 1'b0; m_busy_cycles = 0;
         e_sel1 = 2'b00; e_sel2 = 2'b00; e_start = 1'b0; e_to = 1'b0;
         return;
      end
      start   = 1'b0;
      e_start = 1'b0;
      e_to    = m_expired;
      if (!e_frz) begin
         adv = !ex_flush && !m_lu;
         n1  = adv ? ref_sel(id_rs1, id_use_rs1) : 2'b00;
         n2  = adv ? ref_sel(id_rs2, id_use_rs2) : 2'b00;
         pipe[1] = pipe[0];
         if (adv && id_valid) pipe[0] = '{rd: id_rd, wr: id_regwrite, ld: id_memread};
         else                 pipe[0] = '0;
         e_sel1 = n1;
         e_sel2 = n2;
         start  = !m_busy && adv && id_valid && id_mc;
      end
      if (m_busy) begin
         if (mc_done || m_expired) m_busy = 1'b0;
         else                      m_busy_cycles++;
      end else if (start) begin
         m_busy = 1'b1;
         m_busy_cycles = 0;
         e_start = 1'b1;
      end
   endtask

   // Advance one clock; inputs change only at posedge+1.
   task automatic tick();
      model_comb();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                         input logic u2, input int rd, input logic rw, input logic mr,
                         input logic mc);
      id_valid = v; id_rs1 = RA_W'(rs1); id_use_rs1 = u1;
      id_rs2 = RA_W'(rs2); id_use_rs2 = u2; id_rd = RA_W'(rd);
      id_regwrite = rw; id_memread = mr; id_mc = mc;
   endtask

   task automatic idle_inputs();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      ex_flush = 1'b0;
      mc_done  = 1'b0;
   endtask

   task automatic drain();
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({M1Sel, M2Sel, mc_start, mc_timeout} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_regs: got %b want 000000", {M1Sel, M2Sel, mc_start, mc_timeout});
      end
      n_checks++;
      if ({pc_hold, ifid_hold, idex_bubble, freeze} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_comb: got %b want 0000", {pc_hold, ifid_hold, idex_bubble, freeze});
      end
   endtask

   task automatic test_back_to_back();
      drain();
      set_id(1, 1, 1, 2, 1, 5, 1, 0, 0);             // add x5,x1,x2
      tick();
      set_id(1, 5, 1, 7, 1, 6, 1, 0, 0);             // sub x6,x5,x7
      #1;
      n_checks++;
      if ({pc_hold, ifid_hold, idex_bubble, freeze} !== 4'b0) begin
         n_fail++;
         $display("FAIL b2b_no_hold: got %b want 0000", {pc_hold, ifid_hold, idex_bubble, freeze});
      end
      tick();
      n_checks++;
      if ({M1Sel, M2Sel} !== 4'b1000) begin
         n_fail++;
         $display("FAIL b2b_sel: got %b_%b want 10_00", M1Sel, M2Sel);
      end
      // producer writing x0 must never be forwarded
      drain();
      set_id(1, 1, 1, 2, 1, 0, 1, 0, 0);             // add x0,x1,x2
      tick();
      set_id(1, 0, 1, 0, 1, 6, 1, 0, 0);             // sub x6,x0,x0
      tick();
      n_checks++;
      if ({M1Sel, M2Sel} !== 4'b0000) begin
         n_fail++;
         $display("FAIL b2b_x0_sel: got %b_%b want 00_00", M1Sel, M2Sel);
      end
   endtask

   task automatic test_distance2();
      drain();
      set_id(1, 1, 1, 2, 1, 5, 1, 0, 0);             // add x5
      tick();
      idle_inputs();                                 // nop
      tick();
      set_id(1, 5, 1, 5, 1, 8, 1, 0, 0);             // or x8,x5,x5
      tick();
      n_checks++;
      if ({M1Sel, M2Sel} !== 4'b0101) begin
         n_fail++;
         $display("FAIL dist2_sel: got %b_%b want 01_01", M1Sel, M2Sel);
      end
      drain();
      set_id(1, 1, 1, 2, 1, 0, 1, 0, 0);             // add x0
      tick();
      idle_inputs();
      tick();
      set_id(1, 0, 1, 0, 1, 8, 1, 0, 0);             // or x8,x0,x0
      tick();
      n_checks++;
      if ({M1Sel, M2Sel} !== 4'b0000) begin
         n_fail++;
         $display("FAIL dist2_x0_sel: got %b_%b want 00_00", M1Sel, M2Sel);
      end
   endtask

   task automatic test_load_use();
      int bubbles = 0;
      drain();
      set_id(1, 2, 1, 0, 0, 5, 1, 1, 0);             // lw x5,0(x2)
      tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0, 0);             // add x6,x5,x1
      #1;
      if (idex_bubble) bubbles++;
      n_checks++;
      if ({pc_hold, ifid_hold, idex_bubble, freeze} !== 4'b1110) begin
         n_fail++;
         $display("FAIL lu_stall: got %b want 1110", {pc_hold, ifid_hold, idex_bubble, freeze});
      end
      tick();
      n_checks++;
      if ({M1Sel, M2Sel} !== 4'b0000) begin
         n_fail++;
         $display("FAIL lu_bubble_sel: got %b_%b want 00_00", M1Sel, M2Sel);
      end
      #1;
      if (idex_bubble) bubbles++;
      tick();
      n_checks++;
      if ({M1Sel, M2Sel} !== 4'b0100) begin
         n_fail++;
         $display("FAIL lu_fwd_sel: got %b_%b want 01_00", M1Sel, M2Sel);
      end
      idle_inputs();
      #1;
      if (idex_bubble) bubbles++;
      n_checks++;
      if (bubbles != 1) begin
         n_fail++;
         $display("FAIL lu_bubble_count: got %0d want 1", bubbles);
      end
   endtask

   task automatic test_flush_vs_lu();
      drain();
      set_id(1, 2, 1, 0, 0, 5, 1, 1, 0);             // lw x5
      tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0, 0);             // dependent add
      ex_flush = 1'b1;
      #1;
      n_checks++;
      if ({pc_hold, ifid_hold, idex_bubble, freeze} !== 4'b0010) begin
         n_fail++;
         $display("FAIL flush_lu_outs: got %b want 0010", {pc_hold, ifid_hold, idex_bubble, freeze});
      end
      tick();
      idle_inputs();
      n_checks++;
      if ({M1Sel, M2Sel} !== 4'b0000) begin
         n_fail++;
         $display("FAIL flush_sel: got %b_%b want 00_00", M1Sel, M2Sel);
      end
      set_id(1, 5, 1, 5, 1, 7, 1, 0, 0);             // EX now a bubble: no load-use
      #1;
      n_checks++;
      if ({pc_hold, idex_bubble} !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_after: got %b want 00", {pc_hold, idex_bubble});
      end
      tick();
   endtask

   task automatic test_mac();
      logic [3:0] sels;
      int bad_frz = 0, bad_sel = 0, bad_start = 0;
      drain();
      set_id(1, 1, 1, 2, 1, 9, 1, 0, 0);             // add x9
      tick();
      set_id(1, 9, 1, 3, 1, 10, 1, 0, 1);            // mac x10,x9,x3
      tick();
      set_id(1, 10, 1, 10, 1, 11, 1, 0, 0);          // add x11,x10,x10 waits in ID
      sels = {M1Sel, M2Sel};
      n_checks++;
      if (sels !== 4'b1000) begin
         n_fail++;
         $display("FAIL mac_sel: got %b want 1000", sels);
      end
      n_checks++;
      if (mc_start !== 1'b1) begin
         n_fail++;
         $display("FAIL mac_start: got %b want 1", mc_start);
      end
      for (int k = 1; k <= 9; k++) begin
         ex_flush = (k == 5);                        // ignored while frozen
         #1;
         if ({pc_hold, ifid_hold, idex_bubble, freeze} !== 4'b1101) bad_frz++;
         if ({M1Sel, M2Sel} !== sels) bad_sel++;
         if (k > 1 && mc_start !== 1'b0) bad_start++;
         tick();
      end
      ex_flush = 1'b0;
      n_checks++;
      if (bad_frz != 0 || bad_sel != 0 || bad_start != 0) begin
         n_fail++;
         $display("FAIL mac_busy: frz_err=%0d sel_err=%0d start_err=%0d want 0/0/0",
                  bad_frz, bad_sel, bad_start);
      end
      mc_done = 1'b1;
      #1;
      n_checks++;
      if ({pc_hold, freeze} !== 2'b00) begin
         n_fail++;
         $display("FAIL mac_done_release: got %b want 00", {pc_hold, freeze});
      end
      tick();
      idle_inputs();
      n_checks++;
      if ({M1Sel, M2Sel, freeze} !== 5'b10100) begin
         n_fail++;
         $display("FAIL mac_after: got %b want 10100", {M1Sel, M2Sel, freeze});
      end
      tick();
   endtask

   task automatic test_watchdog();
      int frz_cycles = 0, to_seen = 0, to_at = -1, late = 0;
      drain();
      set_id(1, 0, 0, 0, 0, 12, 1, 0, 1);            // mac x12, never completes
      tick();
      idle_inputs();
      for (int c = 0; c < 150; c++) begin
         #1;
         if (freeze) frz_cycles++;
         tick();
         if (mc_timeout) begin
            to_seen++;
            to_at = c;
         end
      end
      n_checks++;
      if (frz_cycles != MC_MAX - 1) begin
         n_fail++;
         $display("FAIL wd_freeze_len: got %0d want %0d", frz_cycles, MC_MAX - 1);
      end
      n_checks++;
      if (to_seen != 1 || to_at != MC_MAX - 1) begin
         n_fail++;
         $display("FAIL wd_timeout: pulses=%0d at=%0d want 1 at %0d", to_seen, to_at, MC_MAX - 1);
      end
      // reset in the middle of a busy period
      drain();
      set_id(1, 1, 1, 2, 1, 9, 1, 0, 0);
      tick();
      set_id(1, 9, 1, 9, 1, 10, 1, 0, 1);
      tick();
      idle_inputs();
      for (int c = 0; c < 5; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({M1Sel, M2Sel, mc_start, mc_timeout, pc_hold, ifid_hold, idex_bubble, freeze} !== 10'b0) begin
         n_fail++;
         $display("FAIL rst_midbusy: got %b want 0000000000",
                  {M1Sel, M2Sel, mc_start, mc_timeout, pc_hold, ifid_hold, idex_bubble, freeze});
      end
      for (int c = 0; c < 80; c++) begin
         #1;
         if (freeze || mc_timeout) late++;
         tick();
      end
      n_checks++;
      if (late != 0) begin
         n_fail++;
         $display("FAIL rst_no_timeout: got %0d busy/timeout cycles want 0", late);
      end
   endtask

   task automatic test_random();
      int bad_comb = 0, bad_reg = 0;
      for (int i = 0; i < 800; i++) begin
         rst         = ($urandom_range(0, 63) == 0);
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rs1      = RA_W'($urandom_range(0, 3));
         id_rs2      = RA_W'($urandom_range(0, 3));
         id_rd       = RA_W'($urandom_range(0, 3));
         id_use_rs1  = 1'($urandom_range(0, 1));
         id_use_rs2  = 1'($urandom_range(0, 1));
         id_regwrite = ($urandom_range(0, 3) != 0);
         id_memread  = ($urandom_range(0, 2) == 0);
         id_mc       = ($urandom_range(0, 15) == 0);
         ex_flush    = ($urandom_range(0, 7) == 0);
         mc_done     = ($urandom_range(0, 3) == 0);
         #1;
         model_comb();
         n_checks++;
         if ({pc_hold, ifid_hold, idex_bubble, freeze} !== {e_pc, e_ifid, e_bub, e_frz}) begin
            n_fail++;
            if (bad_comb++ < 5)
               $display("FAIL rand_comb[%0d]: got %b want %b", i,
                        {pc_hold, ifid_hold, idex_bubble, freeze}, {e_pc, e_ifid, e_bub, e_frz});
         end
         tick();
         n_checks++;
         if ({M1Sel, M2Sel, mc_start, mc_timeout} !== {e_sel1, e_sel2, e_start, e_to}) begin
            n_fail++;
            if (bad_reg++ < 5)
               $display("FAIL rand_reg[%0d]: got %b want %b", i,
                        {M1Sel, M2Sel, mc_start, mc_timeout}, {e_sel1, e_sel2, e_start, e_to});
         end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      pipe[0] = '0; pipe[1] = '0;
      m_busy = 1'b0; m_busy_cycles = 0;
      e_sel1 = 2'b00; e_sel2 = 2'b00; e_start = 1'b0; e_to = 1'b0;
      rst = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_back_to_back();
      test_distance2();
      test_load_use();
      test_flush_vs_lu();
      test_mac();
      test_watchdog();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
